operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode-side reader for the CPU register file; drives both regfile read ports and returns resolved operands.
- Merges regfile read data with bypass values from the EX, MEM and WB stages.
- Stalls the front end on unresolved hazards; presents operands to EX through a registered valid/ready stage.

Parameters:
- XLEN, 32, datapath width.
- AW, 5, register address width; register 0 is hard-wired zero.
- TAG_W, 32, opaque per-instruction payload passed through to EX (opcode/pc bits).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  operand_fetch accepts this cycle.
- in_rs1, in_rs2  in  AW  source register indices.
- in_use2  in  1  instruction reads rs2; when 0, rs2 is ignored for hazards.
- in_rd  in  AW  destination index, passed through.
- in_tag  in  TAG_W  payload, passed through.
- raddr1, raddr2  out  AW  regfile read addresses, combinational copies of in_rs1/in_rs2.
- rdata1, rdata2  in  XLEN  regfile read data, combinational same-cycle.
- ex_we, ex_waddr(AW), ex_wdata(XLEN), ex_dvalid  in  EX-stage result; ex_dvalid=0 means data not yet available (load).
- mem_we, mem_waddr(AW), mem_wdata(XLEN), mem_dvalid  in  MEM-stage result, same meaning.
- wb_we, wb_waddr(AW), wb_wdata(XLEN)  in  value being written to the regfile this cycle; always valid.
- flush  in  1  squash the output register.
- out_valid  out  1  operands valid to EX.
- out_ready  in  1  EX consumes.
- out_op1, out_op2  out  XLEN  resolved operands.
- out_rd  out  AW; out_tag  out  TAG_W  passed through.
- stall_cnt  out  16  hazard-stall cycle count (Optional Feature only).

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0; out_op1, out_op2, out_rd, out_tag = 0; stall_cnt=0. A reset mid-transfer drops the held instruction.
- Operand select per source, in priority order:
  - index 0 gives 0, regardless of any bypass;
  - EX match (ex_we && ex_waddr==rs) gives ex_wdata;
  - else MEM match gives mem_wdata;
  - else WB match gives wb_wdata (covers write-at-posedge/read-same-cycle);
  - else rdata.
- hazard = for rs1 and (rs2 if in_use2): the highest-priority matching stage is EX with ex_dvalid=0, or MEM with mem_dvalid=0. A lower-priority valid match never overrides a higher-priority invalid one.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Accept (in_valid && in_ready): the output register loads the selected operands, rd and tag; out_valid=1 next cycle. Latency is 1 cycle from accept to out_valid.
- Output held stable while out_valid && !out_ready.
- Output fires and nothing is accepted: out_valid goes to 0.
- Fire and accept in the same cycle: back-to-back load, no bubble.
- flush=1: out_valid goes to 0 next cycle and nothing is accepted; flush overrides a simultaneous accept.
- Index 0 never raises a hazard.

Optional Feature:
- Macro: OPFETCH_STATS_EN.
- Defined: stall_cnt increments on every cycle with in_valid && hazard && !flush, saturating at 16'hFFFF; reset to 0.
- Not defined: stall_cnt is tied to 0 and no counter flops are built.

Test Plan:
- No bypass: regfile r19=123456, r23=654321; rs1=19, rs2=23, no stage writes -> next cycle out_valid=1, op1=123456, op2=654321.
- Priority: rs1=19; EX writes 19=233 (dvalid=1), MEM writes 19=7, WB writes 19=9 -> op1=233. Drop EX -> op1=7. Drop MEM -> op1=9.
- Load-use: EX writes 23 with ex_dvalid=0, rs2=23, in_use2=1 -> in_ready=0 for 1 cycle. Next cycle MEM has 23=555 with dvalid=1 -> accepted, op2=555; stall_cnt=1 when OPFETCH_STATS_EN is defined. Same case with in_use2=0 -> accepted with no stall.
- Zero register: rs1=0 with EX writing 0=99 -> op1=0, no hazard.
- Backpressure/flush: out_ready=0 for 3 cycles -> outputs stable, in_ready=0. flush=1 -> out_valid=0 next cycle. Asserting rst low mid-hold -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read, EX/MEM/WB bypass, hazard stall and a registered valid/ready output stage.
// Optional hazard-stall counter built only when OPFETCH_STATS_EN is defined.
`default_nettype none

module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic             in_use2,
  input  logic [AW-1:0]    in_rd,
  input  logic [TAG_W-1:0] in_tag,
  output logic [AW-1:0]    raddr1,
  output logic [AW-1:0]    raddr2,
  input  logic [XLEN-1:0]  rdata1,
  input  logic [XLEN-1:0]  rdata2,
  input  logic             ex_we,
  input  logic [AW-1:0]    ex_waddr,
  input  logic [XLEN-1:0]  ex_wdata,
  input  logic             ex_dvalid,
  input  logic             mem_we,
  input  logic [AW-1:0]    mem_waddr,
  input  logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_dvalid,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_waddr,
  input  logic [XLEN-1:0]  wb_wdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [AW-1:0]    out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      stall_cnt
);

  // Returns {hazard, value}; the first matching stage wins, even when its data is not ready yet.
  function automatic logic [XLEN:0] resolve(
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] rf_data,
    input logic            e_we,
    input logic [AW-1:0]   e_addr,
    input logic [XLEN-1:0] e_data,
    input logic            e_ok,
    input logic            m_we,
    input logic [AW-1:0]   m_addr,
    input logic [XLEN-1:0] m_data,
    input logic            m_ok,
    input logic            w_we,
    input logic [AW-1:0]   w_addr,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN:0] res;
    res = '0;
    if (rs == '0) begin
      res = '0;
    end else if (e_we && (e_addr == rs)) begin
      res = {!e_ok, e_data};
    end else if (m_we && (m_addr == rs)) begin
      res = {!m_ok, m_data};
    end else if (w_we && (w_addr == rs)) begin
      res = {1'b0, w_data};
    end else begin
      res = {1'b0, rf_data};
    end
    return res;
  endfunction

  logic [XLEN:0]      sel1_s;
  logic [XLEN:0]      sel2_s;
  logic               hazard_s;
  logic               in_ready_s;
  logic               accept_s;

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    op1_q, op1_d;
  logic [XLEN-1:0]    op2_q, op2_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  // Operand selection, hazard detection and handshake.
  always_comb begin
    sel1_s = resolve(in_rs1, rdata1, ex_we, ex_waddr, ex_wdata, ex_dvalid,
                     mem_we, mem_waddr, mem_wdata, mem_dvalid, wb_we, wb_waddr, wb_wdata);
    sel2_s = resolve(in_rs2, rdata2, ex_we, ex_waddr, ex_wdata, ex_dvalid,
                     mem_we, mem_waddr, mem_wdata, mem_dvalid, wb_we, wb_waddr, wb_wdata);
    hazard_s   = sel1_s[XLEN] || (in_use2 && sel2_s[XLEN]);
    in_ready_s = !hazard_s && !flush && (!valid_q || out_ready);
    accept_s   = in_valid && in_ready_s;
  end

  assign in_ready = in_ready_s;

  // Output stage next state: flush squashes, accept loads, fire without accept drains.
  always_comb begin
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      op1_d   = sel1_s[XLEN-1:0];
      op2_d   = sel2_s[XLEN-1:0];
      rd_d    = in_rd;
      tag_d   = in_tag;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_rd    = rd_q;
  assign out_tag   = tag_q;

`ifdef OPFETCH_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles where a valid instruction waits on a hazard.
  always_comb begin
    stall_d = stall_q;
    if (in_valid && hazard_s && !flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table, hand-written handshake/reset sequences and a randomized
// run against a stage-list reference model with a one-entry queue for the output register.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use2;
  logic [31:0] in_tag;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_we, ex_dvalid, mem_we, mem_dvalid, wb_we;
  logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
  logic [31:0] ex_wdata, mem_wdata, wb_wdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1, out_op2, out_tag;
  logic [4:0]  out_rd;
  logic [15:0] stall_cnt;

  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [31:0] tag;
  } xact_t;

  xact_t       mq[$];
  logic [15:0] m_cnt;

  typedef struct {
    int rs1, rs2, use2;
    int exwe, exa, exd, exdv;
    int mwe, ma, md, mdv;
    int wwe, wa, wd;
    int rdy, e1, e2;
  } vec_t;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use2(in_use2), .in_rd(in_rd), .in_tag(in_tag),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_dvalid(ex_dvalid),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_dvalid(mem_dvalid),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_tag(out_tag),
    .stall_cnt(stall_cnt)
  );

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Walk the stages in priority order; the register file is the final always-matching stage.
  function automatic logic [32:0] ref_sel(input logic [4:0] rs);
    logic        st_we [4];
    logic [4:0]  st_a  [4];
    logic [31:0] st_d  [4];
    logic        st_ok [4];
    st_we = '{ex_we, mem_we, wb_we, 1'b1};
    st_a  = '{ex_waddr, mem_waddr, wb_waddr, rs};
    st_d  = '{ex_wdata, mem_wdata, wb_wdata, rf[rs]};
    st_ok = '{ex_dvalid, mem_dvalid, 1'b1, 1'b1};
    if (rs == 5'd0) return 33'd0;
    for (int i = 0; i < 4; i++) begin
      if (st_we[i] && (st_a[i] == rs)) return {!st_ok[i], st_d[i]};
    end
    return 33'd0;
  endfunction

  task automatic clear_inputs();
    in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_use2 = 1'b0; in_rd = 5'd0; in_tag = 32'd0;
    ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; ex_dvalid = 1'b1;
    mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'd0; mem_dvalid = 1'b1;
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  // One clock: check in_ready before the edge, advance the model at the edge, check outputs after.
  task automatic cycle();
    logic [32:0] s1, s2;
    logic        haz, rdy, v, fl, ordy;
    xact_t       x;
    #1;
    s1   = ref_sel(in_rs1);
    s2   = ref_sel(in_rs2);
    haz  = s1[32] || (in_use2 && s2[32]);
    rdy  = !haz && !flush && ((mq.size() == 0) || out_ready);
    v    = in_valid;
    fl   = flush;
    ordy = out_ready;
    x.op1 = s1[31:0]; x.op2 = s2[31:0]; x.rd = in_rd; x.tag = in_tag;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("raddr1", 32'(raddr1), 32'(in_rs1));
    @(posedge clk);
    if (v && haz && !fl && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    if (fl) begin
      mq.delete();
    end else begin
      if ((mq.size() != 0) && ordy) void'(mq.pop_front());
      if (v && rdy) mq.push_back(x);
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_op1", out_op1, mq[0].op1);
      chk("out_op2", out_op2, mq[0].op2);
      chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
      chk("out_tag", out_tag, mq[0].tag);
    end
`ifdef OPFETCH_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`else
    chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mq.delete();
    m_cnt = 16'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_op1", out_op1, 32'd0);
    chk("rst_op2", out_op2, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_tag", out_tag, 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b1;
  endtask

  vec_t vecs[12];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd1000 + 32'(i);
    rf[0]  = 32'hDEAD_BEEF;
    rf[19] = 32'd123456;
    rf[23] = 32'd654321;
    m_cnt  = 16'd0;
    clear_inputs();
    rst = 1'b0;

    //            rs1 rs2 u2  exwe exa exd exdv mwe ma md mdv wwe wa wd  rdy e1      e2
    vecs[0]  = '{19, 23, 1,  0, 0,  0,  1,  0, 0, 0, 1,  0, 0, 0,  1, 123456, 654321};
    vecs[1]  = '{19, 23, 1,  1, 19, 233, 1, 1, 19, 7, 1, 1, 19, 9, 1, 233,    654321};
    vecs[2]  = '{19, 23, 1,  0, 0,  0,  1,  1, 19, 7, 1, 1, 19, 9, 1, 7,      654321};
    vecs[3]  = '{19, 23, 1,  0, 0,  0,  1,  0, 0, 0, 1,  1, 19, 9, 1, 9,      654321};
    vecs[4]  = '{19, 23, 1,  1, 23, 77, 0,  0, 0, 0, 1,  0, 0, 0,  0, 0,      0};
    vecs[5]  = '{19, 23, 0,  1, 23, 77, 0,  0, 0, 0, 1,  0, 0, 0,  1, 123456, 77};
    vecs[6]  = '{0,  23, 1,  1, 0,  99, 0,  0, 0, 0, 1,  0, 0, 0,  1, 0,      654321};
    vecs[7]  = '{5,  23, 1,  1, 5,  11, 0,  1, 5, 22, 1, 0, 0, 0,  0, 0,      0};
    vecs[8]  = '{5,  23, 1,  0, 0,  0,  1,  1, 5, 22, 0, 1, 5, 33, 0, 0,      0};
    vecs[9]  = '{5,  23, 1,  1, 5,  11, 1,  1, 5, 22, 0, 0, 0, 0,  1, 11,     654321};
    vecs[10] = '{5,  0,  1,  0, 0,  0,  1,  0, 0, 0, 1,  1, 5, 33, 1, 33,     0};
    vecs[11] = '{7,  7,  1,  0, 0,  0,  1,  1, 7, 44, 1, 0, 0, 0,  1, 44,     44};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      in_valid = 1'b1;
      in_rs1 = 5'(vecs[i].rs1); in_rs2 = 5'(vecs[i].rs2); in_use2 = 1'(vecs[i].use2);
      in_rd = 5'(i); in_tag = 32'h100 + 32'(i);
      ex_we = 1'(vecs[i].exwe); ex_waddr = 5'(vecs[i].exa); ex_wdata = 32'(vecs[i].exd);
      ex_dvalid = 1'(vecs[i].exdv);
      mem_we = 1'(vecs[i].mwe); mem_waddr = 5'(vecs[i].ma); mem_wdata = 32'(vecs[i].md);
      mem_dvalid = 1'(vecs[i].mdv);
      wb_we = 1'(vecs[i].wwe); wb_waddr = 5'(vecs[i].wa); wb_wdata = 32'(vecs[i].wd);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].rdy));
      if (vecs[i].rdy != 0) begin
        chk($sformatf("vec%0d_op1", i), out_op1, 32'(vecs[i].e1));
        chk($sformatf("vec%0d_op2", i), out_op2, 32'(vecs[i].e2));
      end
    end

    // Load-use: one stall cycle, then MEM supplies the value.
    do_reset();
    clear_inputs();
    in_valid = 1'b1; in_rs1 = 5'd19; in_rs2 = 5'd23; in_use2 = 1'b1; in_tag = 32'h55;
    ex_we = 1'b1; ex_waddr = 5'd23; ex_wdata = 32'd1; ex_dvalid = 1'b0;
    #1;
    chk("lu_stall_ready", 32'(in_ready), 32'd0);
    cycle();
`ifdef OPFETCH_STATS_EN
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
`endif
    ex_we = 1'b0; mem_we = 1'b1; mem_waddr = 5'd23; mem_wdata = 32'd555; mem_dvalid = 1'b1;
    #1;
    chk("lu_accept_ready", 32'(in_ready), 32'd1);
    cycle();
    chk("lu_valid", 32'(out_valid), 32'd1);
    chk("lu_op2", out_op2, 32'd555);

    // Backpressure holds the output, flush squashes it.
    clear_inputs();
    in_valid = 1'b1; in_rs1 = 5'd19; in_rs2 = 5'd23; in_use2 = 1'b1; in_rd = 5'd3; in_tag = 32'hAAAA;
    cycle();
    out_ready = 1'b0; in_rs1 = 5'd1; in_tag = 32'hBBBB;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      cycle();
      chk("bp_op1", out_op1, 32'd123456);
      chk("bp_tag", out_tag, 32'hAAAA);
    end
    flush = 1'b1; in_valid = 1'b1;
    cycle();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("hold_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_op1", out_op1, 32'd0);
    chk("async_rst_tag", out_tag, 32'd0);
    mq.delete();
    m_cnt = 16'd0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rs1     = 5'($urandom_range(0, 7));
      in_rs2     = 5'($urandom_range(0, 7));
      in_use2    = 1'($urandom_range(0, 1));
      in_rd      = 5'($urandom_range(0, 31));
      in_tag     = $urandom;
      ex_we      = 1'($urandom_range(0, 1));
      ex_waddr   = 5'($urandom_range(0, 7));
      ex_wdata   = $urandom;
      ex_dvalid  = ($urandom_range(0, 3) != 0);
      mem_we     = 1'($urandom_range(0, 1));
      mem_waddr  = 5'($urandom_range(0, 7));
      mem_wdata  = $urandom;
      mem_dvalid = ($urandom_range(0, 3) != 0);
      wb_we      = 1'($urandom_range(0, 1));
      wb_waddr   = 5'($urandom_range(0, 7));
      wb_wdata   = $urandom;
      flush      = ($urandom_range(0, 15) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
